// File: rtl/led_sdi_decoder.sv
// Pulse-width decoder for a one-wire LED serial line: recovers 24-bit pixels,
// frame latches and line faults from the synchronised sdi input.
module led_sdi_decoder #(
    parameter int BIT_THRESHOLD  = 12,
    parameter int MIN_HIGH       = 4,
    parameter int MAX_HIGH       = 24,
    parameter int LATCH_CYCLES   = 1000,
    parameter int BITS_PER_PIXEL = 24,
    parameter int INDEX_WIDTH    = 9
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sdi,
    output logic [BITS_PER_PIXEL-1:0] pixel_data,
    output logic                      pixel_valid,
    output logic [INDEX_WIDTH-1:0]    pixel_index,
    output logic                      frame_done,
    output logic [INDEX_WIDTH:0]      frame_pixels,
    output logic                      err_glitch,
    output logic                      err_long,
    output logic                      err_partial
);

    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int BW = $clog2(BITS_PER_PIXEL);

    localparam logic [LW-1:0] LOW_LAST = LW'(LATCH_CYCLES - 1);
    localparam logic [LW-1:0] LOW_FULL = LW'(LATCH_CYCLES);
    localparam logic [HW-1:0] H_MIN    = HW'(MIN_HIGH);
    localparam logic [HW-1:0] H_TH     = HW'(BIT_THRESHOLD);
    localparam logic [HW-1:0] H_MAX    = HW'(MAX_HIGH);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_PIXEL - 1);

    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

    logic                      sdi_meta;
    logic                      sdi_s;
    state_t                    state_reg, state_next;
    logic [LW-1:0]             low_cnt_reg, low_cnt_next;
    logic [HW-1:0]             high_cnt_reg, high_cnt_next;
    // Holds the previous BITS_PER_PIXEL-1 bits; the final bit joins them directly.
    logic [BITS_PER_PIXEL-2:0] shift_reg, shift_next;
    logic [BW-1:0]             bit_cnt_reg, bit_cnt_next;
    logic [INDEX_WIDTH-1:0]    index_reg, index_next;
    logic [INDEX_WIDTH:0]      count_reg, count_next;
    logic [BITS_PER_PIXEL-1:0] pixel_data_reg, pixel_data_next;
    logic [INDEX_WIDTH-1:0]    pixel_index_reg, pixel_index_next;
    logic [INDEX_WIDTH:0]      frame_pixels_reg, frame_pixels_next;
    logic                      pixel_valid_reg, pixel_valid_next;
    logic                      frame_done_reg, frame_done_next;
    logic                      err_glitch_reg, err_glitch_next;
    logic                      err_long_reg, err_long_next;
    logic                      err_partial_reg, err_partial_next;
    logic                      bit_val;

    always_comb begin
        state_next        = state_reg;
        low_cnt_next      = low_cnt_reg;
        high_cnt_next     = high_cnt_reg;
        shift_next        = shift_reg;
        bit_cnt_next      = bit_cnt_reg;
        index_next        = index_reg;
        count_next        = count_reg;
        pixel_data_next   = pixel_data_reg;
        pixel_index_next  = pixel_index_reg;
        frame_pixels_next = frame_pixels_reg;
        pixel_valid_next  = 1'b0;
        frame_done_next   = 1'b0;
        err_glitch_next   = 1'b0;
        err_long_next     = 1'b0;
        err_partial_next  = 1'b0;
        bit_val           = 1'b0;

        case (state_reg)
            SYNC: begin
                if (sdi_s) begin
                    low_cnt_next = '0;
                end else if (low_cnt_reg == LOW_LAST) begin
                    // Aligned to a latch boundary: start the first frame silently.
                    low_cnt_next = LOW_FULL;
                    state_next   = LOW;
                    bit_cnt_next = '0;
                    index_next   = '0;
                    count_next   = '0;
                end else begin
                    low_cnt_next = low_cnt_reg + 1'b1;
                end
            end

            LOW: begin
                if (sdi_s) begin
                    state_next    = HIGH;
                    high_cnt_next = HW'(1);
                    low_cnt_next  = '0;
                end else if (low_cnt_reg < LOW_FULL) begin
                    low_cnt_next = low_cnt_reg + 1'b1;
                    if (low_cnt_reg == LOW_LAST) begin
                        frame_done_next   = 1'b1;
                        frame_pixels_next = count_reg;
                        err_partial_next  = (bit_cnt_reg != '0);
                        bit_cnt_next      = '0;
                        index_next        = '0;
                        count_next        = '0;
                    end
                end
            end

            HIGH: begin
                if (sdi_s) begin
                    if (high_cnt_reg <= H_MAX) begin
                        high_cnt_next = high_cnt_reg + 1'b1;
                    end
                    if (high_cnt_reg == H_MAX) begin
                        err_long_next = 1'b1;
                        state_next    = SYNC;
                        low_cnt_next  = '0;
                        bit_cnt_next  = '0;
                    end
                end else begin
                    // The falling-edge sample is the first low cycle of the gap.
                    state_next   = LOW;
                    low_cnt_next = LW'(1);
                    if (high_cnt_reg < H_MIN) begin
                        err_glitch_next = 1'b1;
                    end else begin
                        bit_val = (high_cnt_reg >= H_TH);
                        if (BITS_PER_PIXEL > 2) begin
                            shift_next = {shift_reg[BITS_PER_PIXEL-3:0], bit_val};
                        end else begin
                            shift_next = bit_val;
                        end
                        if (bit_cnt_reg == BIT_LAST) begin
                            pixel_valid_next = 1'b1;
                            pixel_data_next  = {shift_reg, bit_val};
                            pixel_index_next = index_reg;
                            index_next       = index_reg + 1'b1;
                            if (count_reg != '1) begin
                                count_next = count_reg + 1'b1;
                            end
                            bit_cnt_next = '0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
            end

            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdi_meta         <= 1'b0;
            sdi_s            <= 1'b0;
            state_reg        <= SYNC;
            low_cnt_reg      <= '0;
            high_cnt_reg     <= '0;
            shift_reg        <= '0;
            bit_cnt_reg      <= '0;
            index_reg        <= '0;
            count_reg        <= '0;
            pixel_data_reg   <= '0;
            pixel_index_reg  <= '0;
            frame_pixels_reg <= '0;
            pixel_valid_reg  <= 1'b0;
            frame_done_reg   <= 1'b0;
            err_glitch_reg   <= 1'b0;
            err_long_reg     <= 1'b0;
            err_partial_reg  <= 1'b0;
        end else begin
            sdi_meta         <= sdi;
            sdi_s            <= sdi_meta;
            state_reg        <= state_next;
            low_cnt_reg      <= low_cnt_next;
            high_cnt_reg     <= high_cnt_next;
            shift_reg        <= shift_next;
            bit_cnt_reg      <= bit_cnt_next;
            index_reg        <= index_next;
            count_reg        <= count_next;
            pixel_data_reg   <= pixel_data_next;
            pixel_index_reg  <= pixel_index_next;
            frame_pixels_reg <= frame_pixels_next;
            pixel_valid_reg  <= pixel_valid_next;
            frame_done_reg   <= frame_done_next;
            err_glitch_reg   <= err_glitch_next;
            err_long_reg     <= err_long_next;
            err_partial_reg  <= err_partial_next;
        end
    end

    assign pixel_data   = pixel_data_reg;
    assign pixel_valid  = pixel_valid_reg;
    assign pixel_index  = pixel_index_reg;
    assign frame_done   = frame_done_reg;
    assign frame_pixels = frame_pixels_reg;
    assign err_glitch   = err_glitch_reg;
    assign err_long     = err_long_reg;
    assign err_partial  = err_partial_reg;

endmodule

// File: tb/tb_led_sdi_decoder.sv
// Scoreboard bench: a run-length model of the line predicts decoder events,
// a monitor compares every pulse the decoder emits against that queue.
module tb_led_sdi_decoder;

    localparam int BPP   = 24;
    localparam int IW    = 9;
    localparam int LATCH = 1000;
    localparam int MINH  = 4;
    localparam int MAXH  = 24;
    localparam int TH    = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sdi = 1'b0;
    logic [BPP-1:0] pixel_data;
    logic          pixel_valid;
    logic [IW-1:0] pixel_index;
    logic          frame_done;
    logic [IW:0]   frame_pixels;
    logic          err_glitch;
    logic          err_long;
    logic          err_partial;

    always #5 clk = ~clk;

    led_sdi_decoder dut (
        .clk(clk), .reset_n(reset_n), .sdi(sdi),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
        .frame_done(frame_done), .frame_pixels(frame_pixels),
        .err_glitch(err_glitch), .err_long(err_long), .err_partial(err_partial)
    );

    typedef struct {
        bit             pv;
        logic [BPP-1:0] data;
        int             idx;
        bit             fd;
        int             fp;
        bit             partial;
        bit             glitch;
        bit             lng;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    // Line model: runs of equal level, judged by their lengths alone.
    bit             m_synced;
    int             m_nbits;
    logic [BPP-1:0] m_acc;
    int             m_idx;
    int             m_count;
    bit             run_lvl;
    int             run_len;

    function automatic ev_t blank();
        ev_t e;
        e = '{default: 0};
        return e;
    endfunction

    task automatic model_reset();
        m_synced = 0; m_nbits = 0; m_acc = '0; m_idx = 0; m_count = 0;
        run_lvl = 0; run_len = 0;
    endtask

    task automatic model_fall(input int w);
        ev_t e;
        if (!m_synced) return;
        if (w < MINH) begin
            e = blank(); e.glitch = 1; exp_q.push_back(e);
        end else begin
            m_acc = {m_acc[BPP-2:0], (w >= TH)};
            m_nbits++;
            if (m_nbits == BPP) begin
                e = blank(); e.pv = 1; e.data = m_acc; e.idx = m_idx % (1 << IW);
                exp_q.push_back(e);
                m_idx++;
                if (m_count < (1 << (IW + 1)) - 1) m_count++;
                m_nbits = 0;
            end
        end
    endtask

    task automatic model_latch();
        ev_t e;
        if (m_synced) begin
            e = blank(); e.fd = 1; e.fp = m_count; e.partial = (m_nbits != 0);
            exp_q.push_back(e);
        end
        m_synced = 1; m_nbits = 0; m_idx = 0; m_count = 0;
    endtask

    // Drive sdi at lvl for n cycles; expectations are queued before the DUT can react.
    task automatic seg(input bit lvl, input int n);
        ev_t e;
        if (lvl != run_lvl) begin
            if (run_lvl) model_fall(run_len);
            run_lvl = lvl;
            run_len = 0;
        end
        if (lvl) begin
            if (m_synced && run_len <= MAXH && run_len + n > MAXH) begin
                e = blank(); e.lng = 1; exp_q.push_back(e);
                m_synced = 0; m_nbits = 0;
            end
        end else if (run_len < LATCH && run_len + n >= LATCH) begin
            model_latch();
        end
        run_len += n;
        sdi = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        if ($urandom_range(0, 15) == 0) begin
            seg(1, $urandom_range(1, MINH - 1));
            seg(0, $urandom_range(5, 20));
        end
        seg(1, b ? $urandom_range(TH, MAXH) : $urandom_range(MINH, TH - 1));
        seg(0, $urandom_range(5, 40));
    endtask

    task automatic send_pixel(input logic [BPP-1:0] p);
        for (int i = BPP - 1; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic send_fixed(input logic [BPP-1:0] p, input int glitch_after);
        for (int i = BPP - 1; i >= 0; i--) begin
            if (p[i]) begin seg(1, 16); seg(0, 9); end
            else      begin seg(1, 8);  seg(0, 17); end
            if (BPP - i == glitch_after) begin seg(1, 2); seg(0, 9); end
        end
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (pixel_data !== '0 || pixel_index !== '0 || frame_pixels !== '0 ||
            {pixel_valid, frame_done, err_glitch, err_long, err_partial} !== 5'b0) begin
            failures++;
            $display("FAIL %s: data=%h idx=%0d fp=%0d pulses=%b, required all zero",
                     tag, pixel_data, pixel_index, frame_pixels,
                     {pixel_valid, frame_done, err_glitch, err_long, err_partial});
        end
    endtask

    // Monitor: every cycle carrying a pulse is one transaction.
    always @(negedge clk) begin
        ev_t g, e;
        if (reset_n && (pixel_valid || frame_done || err_glitch || err_long || err_partial)) begin
            g = blank();
            g.pv = pixel_valid; g.data = pixel_data; g.idx = int'(pixel_index);
            g.fd = frame_done; g.fp = int'(frame_pixels); g.partial = err_partial;
            g.glitch = err_glitch; g.lng = err_long;
            $display("EVENT t=%0t pv=%0b data=%h idx=%0d fd=%0b fp=%0d glitch=%0b long=%0b partial=%0b",
                     $time, g.pv, g.data, g.idx, g.fd, g.fp, g.glitch, g.lng, g.partial);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got pv=%0b fd=%0b glitch=%0b long=%0b partial=%0b, required no event",
                         g.pv, g.fd, g.glitch, g.lng, g.partial);
            end else begin
                e = exp_q.pop_front();
                if (g.pv != e.pv || g.fd != e.fd || g.glitch != e.glitch || g.lng != e.lng ||
                    g.partial != e.partial || (e.pv && (g.data !== e.data || g.idx != e.idx)) ||
                    (e.fd && g.fp != e.fp)) begin
                    failures++;
                    $display("FAIL event: got pv=%0b data=%h idx=%0d fd=%0b fp=%0d g=%0b l=%0b p=%0b, required pv=%0b data=%h idx=%0d fd=%0b fp=%0d g=%0b l=%0b p=%0b",
                             g.pv, g.data, g.idx, g.fd, g.fp, g.glitch, g.lng, g.partial,
                             e.pv, e.data, e.idx, e.fd, e.fp, e.glitch, e.lng, e.partial);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (4) @(negedge clk);
        check_reset_outputs("reset_initial");
        reset_n = 1'b1;

        // Reference frame with fixed timing.
        seg(0, LATCH);
        send_fixed(24'hA5C30F, 0);
        seg(0, LATCH);

        // Three pixels, one frame.
        send_pixel(24'h000001);
        send_pixel(24'hFFFFFF);
        send_pixel(24'h800000);
        seg(0, LATCH);

        // Glitch between bits 5 and 6.
        send_fixed(24'h5A3C96, 5);
        seg(0, LATCH);

        // Width boundaries: 4 and 11 decode 0, 12 and 24 decode 1, 3 is a glitch; 999 low is no latch.
        for (int i = 0; i < 6; i++) begin
            seg(1, 4); seg(0, 6); seg(1, 12); seg(0, 6);
        end
        seg(1, 3); seg(0, 999);
        for (int i = 0; i < 6; i++) begin
            seg(1, 11); seg(0, 6); seg(1, 24); seg(0, 6);
        end
        seg(0, LATCH);

        // Over-long high mid-pixel, then resync and a fresh frame.
        send_bits(10);
        seg(1, 30);
        seg(0, LATCH);
        send_pixel(24'h13579B);
        seg(0, LATCH);
        seg(1, 25);
        seg(0, LATCH + 3);

        // Partial frame, then an empty frame closed by a glitch-separated latch.
        send_pixel(24'h2468AC);
        seg(0, LATCH);
        send_bits(10);
        seg(0, LATCH);
        seg(1, 2);
        seg(0, LATCH);

        // Reset during bit 12, resend without a latch, then resume.
        send_bits(11);
        seg(1, 5);
        reset_n = 1'b0;
        sdi = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_mid_pixel");
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_pending: got %0d queued events, required 0", exp_q.size());
        end
        exp_q.delete();
        model_reset();
        reset_n = 1'b1;
        seg(0, 20);
        send_pixel(24'hC0FFEE);
        seg(0, LATCH);
        send_pixel(24'hBADA55);
        seg(0, LATCH);

        // Randomised frames.
        for (int f = 0; f < 12; f++) begin
            int np;
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) send_pixel(BPP'($urandom));
            if ($urandom_range(0, 3) == 0) send_bits($urandom_range(1, BPP - 1));
            if ($urandom_range(0, 7) == 0) seg(1, $urandom_range(MAXH + 1, MAXH + 10));
            seg(0, $urandom_range(LATCH, LATCH + 10));
        end

        // Bounded drain of anything still outstanding.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: got %0d unmatched expectations, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
